// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one uart transmitter among NUM_REQ byte sources.
// Launch is visible one cycle after req_valid; requesters hold valid/data until req_ack; a watchdog frees a stalled uart or owner.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 131072
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ*8-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ack,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 timeout_err,
   output logic                 uart_tx_en,
   output logic [7:0]           uart_tx_data,
   input  logic                 uart_tx_done
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
   localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, WAIT_DONE, LOCKED} state_t;

   state_t             state_q;
   state_t             state_nxt;
   logic [IW-1:0]      rr_ptr_q;
   logic [IW-1:0]      rr_ptr_nxt;
   logic [IW-1:0]      owner_q;
   logic [IW-1:0]      owner_nxt;
   logic               locked_q;
   logic               locked_nxt;
   logic [WW-1:0]      wd_cnt_q;
   logic [WW-1:0]      wd_cnt_nxt;

   logic               launch;
   logic [IW-1:0]      launch_idx;
   logic               done_evt;
   logic               wd_fire;
   logic               wd_max;
   logic [IW-1:0]      rr_after_owner;
   logic [IW-1:0]      pick_idx;
   int                 pick_pos;

   logic [NUM_REQ-1:0] ack_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic               tx_en_nxt;
   logic               err_nxt;
   logic [7:0]         tx_data_nxt;

   assign wd_max         = (wd_cnt_q == WD_MAX);
   assign rr_after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
   assign busy           = (state_q != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         locked_q     <= 1'b0;
         wd_cnt_q     <= '0;
         req_ack      <= '0;
         grant        <= '0;
         timeout_err  <= 1'b0;
         uart_tx_en   <= 1'b0;
         uart_tx_data <= 8'h00;
      end else begin
         state_q      <= state_nxt;
         rr_ptr_q     <= rr_ptr_nxt;
         owner_q      <= owner_nxt;
         locked_q     <= locked_nxt;
         wd_cnt_q     <= wd_cnt_nxt;
         req_ack      <= ack_nxt;
         grant        <= grant_nxt;
         timeout_err  <= err_nxt;
         uart_tx_en   <= tx_en_nxt;
         uart_tx_data <= tx_data_nxt;
      end
   end

   always_comb begin
      state_nxt  = state_q;
      launch     = 1'b0;
      launch_idx = owner_q;
      done_evt   = 1'b0;
      wd_fire    = 1'b0;
      pick_pos   = 0;
      pick_idx   = '0;
      case (state_q)
         IDLE: begin
            // Scan from lowest to highest priority so the rr_ptr-nearest valid wins last.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
               pick_pos = int'(rr_ptr_q) + k;
               if (pick_pos >= NUM_REQ) begin
                  pick_pos = pick_pos - NUM_REQ;
               end
               pick_idx = IW'(pick_pos);
               if (req_valid[pick_idx]) begin
                  launch     = 1'b1;
                  launch_idx = pick_idx;
               end
            end
            if (launch) begin
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (uart_tx_done) begin
               done_evt  = 1'b1;
               state_nxt = locked_q ? LOCKED : IDLE;
            end else if (wd_max) begin
               wd_fire   = 1'b1;
               state_nxt = IDLE;
            end
         end
         LOCKED: begin
            if (req_valid[owner_q]) begin
               launch    = 1'b1;
               state_nxt = WAIT_DONE;
            end else if (wd_max) begin
               wd_fire   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ack_nxt     = '0;
      grant_nxt   = grant;
      tx_en_nxt   = 1'b0;
      err_nxt     = 1'b0;
      tx_data_nxt = uart_tx_data;
      owner_nxt   = owner_q;
      locked_nxt  = locked_q;
      rr_ptr_nxt  = rr_ptr_q;
      wd_cnt_nxt  = wd_cnt_q;
      if (launch) begin
         tx_data_nxt         = req_data[{launch_idx, 3'b000} +: 8];
         tx_en_nxt           = 1'b1;
         ack_nxt[launch_idx] = 1'b1;
         grant_nxt           = '0;
         grant_nxt[launch_idx] = 1'b1;
         owner_nxt           = launch_idx;
         locked_nxt          = ~req_last[launch_idx];
         wd_cnt_nxt          = '0;
      end else if (done_evt) begin
         wd_cnt_nxt = '0;
         if (!locked_q) begin
            rr_ptr_nxt = rr_after_owner;
            grant_nxt  = '0;
         end
      end else if (wd_fire) begin
         err_nxt    = 1'b1;
         locked_nxt = 1'b0;
         rr_ptr_nxt = rr_after_owner;
         grant_nxt  = '0;
         wd_cnt_nxt = '0;
      end else if (state_q != IDLE) begin
         wd_cnt_nxt = wd_cnt_q + WW'(1);
      end
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart` transmitter between up to NUM_REQ byte sources. It uses round-robin arbitration with packet locking, so a multi-byte message from one source is never interleaved with bytes from another. It sits between the client logic and the `uart` block's `tx_en`/`tx_data`/`tx_done` port, and sequences one byte at a time. A watchdog recovers if `tx_done` never arrives or a locked owner stalls.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 131072: watchdog limit in clk cycles. This exceeds one 10-bit frame at 9600 baud from 50 MHz, which is about 52083 cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte pending; held until acked.
- req_data  in  NUM_REQ*8  byte of requester i on bits [8i+7:8i]; held stable while valid.
- req_last  in  NUM_REQ  pending byte is the last byte of its packet.
- req_ack  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i captured.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.
- uart_tx_en  out  1  one-cycle start pulse to the `uart` `tx_en`.
- uart_tx_data  out  8  byte to the `uart` `tx_data`; held until the next launch.
- uart_tx_done  in  1  completion pulse from the `uart` `tx_done`.

## Operation
- States are IDLE, WAIT_DONE and LOCKED.
- Internal registers:
  - `rr_ptr`: index of the highest-priority requester; reset 0.
  - `owner`: index of the current owner.
  - `locked`: packet lock flag.
  - `wd_cnt`: watchdog counter, width $clog2(TIMEOUT_CYCLES+1).
- **Launch**, performed on one clock edge:
  - Set uart_tx_data to the owner's req_data and pulse uart_tx_en.
  - Pulse req_ack[owner] and set grant to onehot(owner).
  - Set locked to ~req_last[owner], clear wd_cnt, and go to WAIT_DONE.
- **IDLE**:
  - If any req_valid is high, pick the first valid index searching rr_ptr, rr_ptr+1, … mod NUM_REQ, then launch.
  - Otherwise stay in IDLE with grant = 0.
- **WAIT_DONE**: increment wd_cnt each cycle.
  - On uart_tx_done, clear wd_cnt.
    - If locked, go to LOCKED and keep grant.
    - Otherwise set rr_ptr to (owner+1) mod NUM_REQ, set grant to 0, and go to IDLE.
  - If wd_cnt reaches TIMEOUT_CYCLES-1 without done:
    - Pulse timeout_err and clear locked.
    - Set rr_ptr to owner+1 mod NUM_REQ, set grant to 0, and go to IDLE.
- **LOCKED**: only req_valid[owner] is considered; all other requesters are blocked.
  - If req_valid[owner] is high, launch for owner.
  - Otherwise increment wd_cnt. At TIMEOUT_CYCLES-1, pulse timeout_err, release the lock, advance rr_ptr and go to IDLE.
- uart_tx_done is sampled only in WAIT_DONE; pulses in IDLE or LOCKED are ignored.
- req_valid on non-granted requesters never produces an ack while another requester owns the UART.
- A requester that drops req_valid before its ack is simply not selected. Data is never sampled from a deasserted requester.

## Timing
- Reset values: req_ack = 0, grant = 0, busy = 0, timeout_err = 0, uart_tx_en = 0, uart_tx_data = 8'h00. Internally, state = IDLE, rr_ptr = 0, locked = 0, wd_cnt = 0.
- Asserting rst mid-transfer aborts immediately. No ack or tx_en is issued after reset, even if the `uart` still completes the frame later.
- Request latency: req_valid high in cycle T (state IDLE or LOCKED) gives uart_tx_en, req_ack and grant at the edge ending T, i.e. visible in cycle T+1.
- Back-to-back: uart_tx_done in cycle D gives the next uart_tx_en in cycle D+2 at the earliest.
- Requester contract: hold valid and data until ack is seen. In the ack cycle, present the next byte or drop valid. The arbiter is in WAIT_DONE during the ack cycle and ignores req_valid then.
- Simultaneous requests are resolved by rr_ptr order only. A requester granted in one arbitration has the lowest priority in the next.

## Test plan
- **Single byte**: req_valid[2] = 1, data 8'h41, last = 1.
  - Expect one uart_tx_en with uart_tx_data 8'h41, req_ack = 4'b0100 one cycle, grant = 4'b0100 until done.
  - After the bench `uart` model's done (20-cycle delay), expect grant = 0 and busy = 0.
- **Round-robin**: all four requesters valid continuously with last = 1.
  - Expect byte order 0,1,2,3,0,1.
  - Expect exactly one ack per launch and a tx_en-to-tx_en spacing of done delay + 2.
- **Packet lock**: requester 1 sends 3 bytes 8'h10, 8'h11, 8'h12 (last on the third) while requester 0 stays valid.
  - Expect all three bytes from requester 1 before any byte from requester 0.
  - Expect requester 0 to be granted next.
- **Done watchdog**: the model never returns done; use TIMEOUT_CYCLES = 64.
  - Expect timeout_err pulse 64 cycles after tx_en, then grant = 0.
  - Expect the next pending requester to launch 2 cycles later.
- **Locked-owner stall**: requester 3 sends a byte with last = 0, then deasserts valid.
  - Expect timeout_err after 64 cycles in LOCKED, then requester 0 is served.
- **Reset mid-operation**: assert rst during WAIT_DONE.
  - Expect all outputs to reach reset values asynchronously.
  - Expect a stray uart_tx_done after release to be ignored, and normal arbitration from requester 0.
